psi_seq_ctrl: RTL and testbench

Sequential controller that computes private-set-intersection membership over a single shared B-bit AND datapath. Instead of a wide combinational AND over all parties' bit-vectors at once, it accepts each party's B-bit set vector as one beat on a valid/ready stream, in party order. It folds each beat into an accumulator and emits the intersection vector plus its cardinality. It sits between party input buffers and the output/garbling stage of the PSI flow.

---
 rtl/psi_pkg.sv | 17 +
 rtl/psi_popcount.sv | 19 +
 rtl/psi_seq_ctrl.sv | 100 ++++++++++
 tb/tb_psi_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/psi_pkg.sv
// Shared definitions for the PSI sequential membership controller.
package psi_pkg;

  localparam int N_PARTIES_DEF = 5;
  localparam int B_DEF         = 10;
  localparam int CNT_W         = $clog2(N_PARTIES_DEF);
  localparam int CARD_W        = $clog2(B_DEF + 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_OUT   = 1'b1;

  typedef enum logic [0:0] {
    ACCUM = ST_ACCUM,
    OUT   = ST_OUT
  } psi_state_e;

endpackage

// File: rtl/psi_popcount.sv
// Combinational population count of a B-bit set vector.
module psi_popcount
  import psi_pkg::*;
#(
  parameter int B      = B_DEF,
  parameter int CARD_W = $clog2(B + 1)
) (
  input  logic [B-1:0]      vec,
  output logic [CARD_W-1:0] card
);

  always_comb begin
    card = '0;
    for (int i = 0; i < B; i++) begin
      card = card + CARD_W'(vec[i]);
    end
  end

endmodule

// File: rtl/psi_seq_ctrl.sv
// Folds one party set vector per beat into an AND accumulator and
// presents the intersection and its cardinality once all parties arrive.
module psi_seq_ctrl
  import psi_pkg::*;
#(
  parameter int N_PARTIES = N_PARTIES_DEF,
  parameter int B         = B_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           abort,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [B-1:0]                   in_data,
  input  logic [$clog2(N_PARTIES)-1:0]   in_party,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [B-1:0]                   out_set,
  output logic [$clog2(B+1)-1:0]         out_card,
  output logic                           err
);

  localparam int CW = $clog2(N_PARTIES);
  localparam int KW = $clog2(B + 1);
  localparam logic [CW-1:0] LAST = CW'(N_PARTIES - 1);

  psi_state_e    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [B-1:0]  acc_reg;
  logic [KW-1:0] card_reg;
  logic          err_reg;

  logic [B-1:0]  acc_next;
  logic [KW-1:0] card_next;
  logic          beat_fire;
  logic          in_order;

  // Handshake flags depend only on registered state.
  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == OUT);
  assign out_set   = acc_reg;
  assign out_card  = card_reg;
  assign err       = err_reg;

  assign beat_fire = in_valid && in_ready;
  // Party indices beyond the last valid one can never match cnt_reg.
  assign in_order  = (in_party == cnt_reg);

  always_comb begin
    acc_next = (cnt_reg == '0) ? in_data : (acc_reg & in_data);
  end

  psi_popcount #(
    .B      (B),
    .CARD_W (KW)
  ) u_popcount (
    .vec  (acc_next),
    .card (card_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACCUM;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      card_reg  <= '0;
      err_reg   <= 1'b0;
    end else if (abort) begin
      state_reg <= ACCUM;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (beat_fire) begin
            if (in_order) begin
              acc_reg <= acc_next;
              if (cnt_reg == LAST) begin
                card_reg  <= card_next;
                cnt_reg   <= '0;
                state_reg <= OUT;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end else begin
              cnt_reg <= '0;
              err_reg <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_psi_seq_ctrl.sv
// Directed scoreboard bench for psi_seq_ctrl with N_PARTIES=5, B=10.
module tb_psi_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic [2:0] in_party;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_set;
  logic [3:0] out_card;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_set_q[$];
  logic [3:0] exp_card_q[$];

  psi_seq_ctrl #(.N_PARTIES(5), .B(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_party  (in_party),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_set   (out_set),
    .out_card  (out_card),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] p, input logic [9:0] d);
    in_valid = 1'b1;
    in_party = p;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [9:0] s, input logic [3:0] c);
    exp_set_q.push_back(s);
    exp_card_q.push_back(c);
  endtask

  // Result monitor: every taken result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_set_q.size() == 0) begin
        chk("unexpected_result", {22'b0, out_set}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] es;
        logic [3:0] ec;
        es = exp_set_q.pop_front();
        ec = exp_card_q.pop_front();
        chk("sb_set", {22'b0, out_set}, {22'b0, es});
        chk("sb_card", {28'b0, out_card}, {28'b0, ec});
        $display("result set=%03h card=%0d", out_set, out_card);
      end
    end
  end

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; in_party = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_set", {22'b0, out_set}, 32'd0);
    chk("rst_out_card", {28'b0, out_card}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);

    // In-order round, consumer always ready.
    out_ready = 1'b1;
    push(10'h0AA, 4'd4);
    send(3'd0, 10'h3FF);
    send(3'd1, 10'h2AA);
    send(3'd2, 10'h3AA);
    send(3'd3, 10'h0AA);
    send(3'd4, 10'h0FA);
    chk("inord_out_valid", {31'b0, out_valid}, 32'd1);
    chk("inord_in_ready", {31'b0, in_ready}, 32'd0);
    chk("inord_set", {22'b0, out_set}, 32'h0AA);
    chk("inord_card", {28'b0, out_card}, 32'd4);
    chk("inord_err", {31'b0, err}, 32'd0);
    tick();
    chk("inord_turn_in_ready", {31'b0, in_ready}, 32'd1);
    chk("inord_turn_out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: result must hold for 6 cycles.
    out_ready = 1'b0;
    push(10'h0AA, 4'd4);
    send(3'd0, 10'h3FF);
    send(3'd1, 10'h2AA);
    send(3'd2, 10'h3AA);
    send(3'd3, 10'h0AA);
    send(3'd4, 10'h0FA);
    for (int i = 0; i < 6; i++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_set", {22'b0, out_set}, 32'h0AA);
      chk("bp_card", {28'b0, out_card}, 32'd4);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

    // Out-of-order beat ends the round and sets err.
    send(3'd0, 10'h3FF);
    send(3'd2, 10'h3FF);
    chk("ooo_err", {31'b0, err}, 32'd1);
    chk("ooo_cnt", {29'b0, dut.cnt_reg}, 32'd0);
    chk("ooo_out_valid", {31'b0, out_valid}, 32'd0);
    push(10'h3FF, 4'd10);
    for (int p = 0; p < 5; p++) send(3'(p), 10'h3FF);
    chk("ooo_full_set", {22'b0, out_set}, 32'h3FF);
    chk("ooo_full_card", {28'b0, out_card}, 32'd10);
    chk("ooo_err_sticky", {31'b0, err}, 32'd1);
    tick();

    // Abort mid-round with a coincident party-3 beat.
    send(3'd0, 10'h001);
    send(3'd1, 10'h001);
    send(3'd2, 10'h001);
    abort = 1'b1;
    send(3'd3, 10'h001);
    abort = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_cnt", {29'b0, dut.cnt_reg}, 32'd0);
    push(10'h001, 4'd1);
    for (int p = 0; p < 5; p++) send(3'(p), 10'h001);
    chk("abort_round_set", {22'b0, out_set}, 32'h001);
    chk("abort_round_card", {28'b0, out_card}, 32'd1);
    tick();

    // Empty intersection.
    push(10'h000, 4'd0);
    send(3'd0, 10'h3FF);
    send(3'd1, 10'h3FF);
    send(3'd2, 10'h3FF);
    send(3'd3, 10'h000);
    send(3'd4, 10'h3FF);
    chk("empty_valid", {31'b0, out_valid}, 32'd1);
    chk("empty_card", {28'b0, out_card}, 32'd0);
    tick();

    // Out-of-range party at the last slot: no OUT transition.
    send(3'd0, 10'h3FF);
    send(3'd1, 10'h3FF);
    send(3'd2, 10'h3FF);
    send(3'd3, 10'h3FF);
    send(3'd7, 10'h3FF);
    chk("range_out_valid", {31'b0, out_valid}, 32'd0);
    chk("range_cnt", {29'b0, dut.cnt_reg}, 32'd0);
    chk("range_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset while a result is pending discards it.
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) send(3'(p), 10'h155);
    chk("rstout_valid_before", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstout_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstout_set", {22'b0, out_set}, 32'd0);
    chk("rstout_card", {28'b0, out_card}, 32'd0);
    chk("rstout_err", {31'b0, err}, 32'd0);
    chk("rstout_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (2) tick();

    chk("sb_drained", exp_set_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
